// File: rtl/terminal_rx_buffer.sv
// Byte FIFO between the serial receiver and terminal_stream, presenting one byte at most every other cycle.
// Optional RTS flow control with hysteresis is built when TERMINAL_RX_BUFFER_RTS_EN is defined.
module terminal_rx_buffer #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned RTS_HIGH   = 192,
  parameter int unsigned RTS_LOW    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  ready_n,
  output logic [7:0]            unicode,
  output logic                  unicode_available,
  output logic                  rts_n,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  if (RTS_LOW >= RTS_HIGH || RTS_HIGH >= Depth) begin : g_cfg_check
    $error("terminal_rx_buffer: thresholds must satisfy RTS_LOW < RTS_HIGH < depth");
  end

  typedef enum logic {
    StIdle    = 1'b0,
    StPresent = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             mem_q [Depth];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [7:0]             unicode_q, unicode_d;
  logic                   avail_q, avail_d;
  logic                   overflow_q, overflow_d;
  logic                   full_c, empty_c, pop_c, push_c;

  // Output state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state: a presented byte always returns to idle the following edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (!empty_c && !ready_n) state_d = StPresent;
      StPresent: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign full_c  = (count_q == CntW'(Depth));
  assign empty_c = (count_q == '0);

  // Pop/push decisions and next values of the datapath registers
  always_comb begin
    pop_c      = 1'b0;
    push_c     = 1'b0;
    unicode_d  = unicode_q;
    avail_d    = 1'b0;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (state_q == StIdle && !empty_c && !ready_n) begin
      pop_c     = 1'b1;
      unicode_d = mem_q[rd_ptr_q];
      avail_d   = 1'b1;
      rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
    end

    // A full FIFO still accepts a byte when a slot frees on the same edge
    if (rx_valid) begin
      if (!full_c || pop_c) begin
        push_c   = 1'b1;
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unicode_q  <= '0;
      avail_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unicode_q  <= unicode_d;
      avail_q    <= avail_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef TERMINAL_RX_BUFFER_RTS_EN
  logic rts_n_q, rts_n_d;

  // Hysteresis: hold the previous value between the two thresholds
  always_comb begin
    rts_n_d = rts_n_q;
    if (count_q >= CntW'(RTS_HIGH))     rts_n_d = 1'b1;
    else if (count_q <= CntW'(RTS_LOW)) rts_n_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rts_n_q <= 1'b0;
    else       rts_n_q <= rts_n_d;
  end

  assign rts_n = rts_n_q;
`else
  assign rts_n = 1'b0;
`endif

  assign unicode           = unicode_q;
  assign unicode_available = avail_q;
  assign overflow          = overflow_q;
  assign fill_level        = count_q;

endmodule
